stream_mux_rr: RTL

Parametrised N-channel, W-bit registered stream multiplexer with per-channel valid/ready handshake. Two modes: fixed select, where a software-driven sel picks one channel, and round-robin arbitration across all requesting channels. It is the sequential successor of the team's combinational 4:1 mux and sits between several producers and a single downstream consumer. The output is registered, and the index of the channel that supplied each beat travels with the data.

---
 rtl/stream_mux_rr_pkg.sv | 16 +
 rtl/stream_mux_rr_if.sv | 41 ++++
 rtl/stream_mux_rr_arbiter.sv | 30 +++
 rtl/stream_mux_rr.sv | 139 +++++++++++++
 4 files changed

// File: rtl/stream_mux_rr_pkg.sv
// Shared constants for the registered round-robin stream multiplexer.
// Optional packet locking is enabled with the STREAM_MUX_PKT_LOCK_EN macro.
package stream_mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int unsigned N_CH_MIN = 2;
    localparam int unsigned N_CH_MAX = 16;

    // Next channel index after idx, wrapping at n
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Stream bundle between N_CH producers, the mux and one consumer.
// in_last/out_last exist only when STREAM_MUX_PKT_LOCK_EN is defined.
interface stream_mux_rr_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned DW   = 8
);
    localparam int unsigned SELW = $clog2(N_CH);

    logic [N_CH-1:0]    in_valid;
    logic [N_CH*DW-1:0] in_data;
    logic [N_CH-1:0]    in_ready;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic [SELW-1:0]    out_ch;
    logic               out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [N_CH-1:0]    in_last;
    logic               out_last;
`endif

    // Producer/consumer side
    modport master (
        output in_valid, in_data, out_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
        output in_last,
        input  out_last,
`endif
        input  in_ready, out_valid, out_data, out_ch
    );

    // Mux side
    modport slave (
        input  in_valid, in_data, out_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
        input  in_last,
        output out_last,
`endif
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned N_CH = 4,
    localparam int unsigned SELW = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic [N_CH-1:0] gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    // Walk channels starting at ptr; the first one requesting wins
    always_comb begin
        logic [SELW-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = SELW'((32'(ptr) + k) % N_CH);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N_CH-to-1 registered stream mux with fixed-select or round-robin grant.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant for a whole packet.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter  int unsigned N_CH = 4,
    parameter  int unsigned DW   = 8,
    localparam int unsigned SELW = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    stream_mux_rr_if.slave    s
);

    logic [SELW-1:0] rr_ptr;
    logic            load;
    logic            gnt_vld;
    logic [SELW-1:0] gnt_idx;
    logic [N_CH-1:0] gnt_oh;
    logic            xfer;
    logic [DW-1:0]   gnt_data;
    logic [N_CH-1:0] arb_gnt;
    logic [SELW-1:0] arb_idx;
    logic            arb_any;
    logic            ptr_adv;
    logic [SELW-1:0] ptr_next;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic            lock_q;
    logic [SELW-1:0] lock_ch_q;
    logic            gnt_last;
`endif

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req     (s.in_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Output stage accepts a new beat when empty or being drained
    assign load = !s.out_valid || s.out_ready;

    // Grant selection: packet lock overrides, else mode picks fixed or rotating
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (mode == MODE_RR) begin
            gnt_vld = arb_any;
            gnt_idx = arb_idx;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (SELW'(i) == sel && s.in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock_q) begin
            gnt_vld = 1'b0;
            gnt_idx = lock_ch_q;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (SELW'(i) == lock_ch_q && s.in_valid[i]) begin
                    gnt_vld = 1'b1;
                end
            end
        end
`endif
    end

    // One-hot grant, granted data and per-channel ready
    always_comb begin
        gnt_oh   = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (SELW'(i) == gnt_idx) begin
                gnt_oh[i] = gnt_vld;
                gnt_data  = s.in_data[i*DW +: DW];
            end
        end
        s.in_ready = (rst_n && load) ? gnt_oh : '0;
    end

    assign xfer     = |(s.in_ready & s.in_valid);
    assign ptr_next = SELW'(wrap_inc(32'(gnt_idx), N_CH));

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Last flag of the granted channel
    always_comb begin
        gnt_last = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (SELW'(i) == gnt_idx) gnt_last = s.in_last[i];
        end
    end
    assign ptr_adv = xfer && (mode == MODE_RR) && gnt_last;
`else
    assign ptr_adv = xfer && (mode == MODE_RR);
`endif

    // Output register, round-robin pointer and packet lock
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
            s.out_ch    <= '0;
            rr_ptr      <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            s.out_last  <= 1'b0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            if (load) begin
                if (xfer) begin
                    s.out_valid <= 1'b1;
                    s.out_data  <= gnt_data;
                    s.out_ch    <= gnt_idx;
`ifdef STREAM_MUX_PKT_LOCK_EN
                    s.out_last  <= gnt_last;
`endif
                end else begin
                    s.out_valid <= 1'b0;
                end
            end
            if (ptr_adv) rr_ptr <= ptr_next;
`ifdef STREAM_MUX_PKT_LOCK_EN
            if (xfer) begin
                lock_q    <= !gnt_last;
                lock_ch_q <= gnt_idx;
            end
`endif
        end
    end

endmodule
